// File: rtl/uart_csr_fifo.sv
// uart_csr_fifo: UART control/status register block with a TX holding FIFO.
// Decodes simple CSR read/write strobes. Holds the line configuration, the TX/RX level
// thresholds, the interrupt enable/pending bits and the saturating error counters.
// Ports:
//   clk, reset_n            single clock, asynchronous active-low reset
//   addr/rden/wren/wdata    CSR access strobes from the bus front end
//   rdata                   registered read data, held until the next read
//   irq                     level interrupt
//   txd/tx_vld/tx_done      TX FIFO head towards the TX engine
//   rxd/rx_perr/rx_overrun/rx_vld/rx_items   RX FIFO head and status
//   rx_done                 pop pulse to the RX FIFO
//   division/width/parity/even/stop          line configuration
//   fifo_clr                RX FIFO clear pulse
module uart_csr_fifo #(
   parameter int unsigned BAUD_RATE = 115_200,
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter logic [31:0] VERSION   = 32'h2024_1001,
   parameter logic [31:0] NAME      = "UART",
   parameter int unsigned TX_DEPTH  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  addr,
   input  logic        rden,
   input  logic        wren,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   output logic [7:0]  txd,
   output logic        tx_vld,
   input  logic        tx_done,
   input  logic [7:0]  rxd,
   input  logic        rx_perr,
   input  logic        rx_overrun,
   input  logic        rx_vld,
   output logic        rx_done,
   input  logic [7:0]  rx_items,
   output logic [15:0] division,
   output logic        width,
   output logic        parity,
   output logic        even,
   output logic        stop,
   output logic        fifo_clr
);

   localparam int unsigned TX_AW       = $clog2(TX_DEPTH);
   localparam logic [15:0] DIVISION    = 16'((CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE);
   localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

   localparam logic [7:0] A_VERSION = 8'h00;
   localparam logic [7:0] A_NAME    = 8'h04;
   localparam logic [7:0] A_CONTROL = 8'h10;
   localparam logic [7:0] A_STATUS  = 8'h14;
   localparam logic [7:0] A_TX      = 8'h18;
   localparam logic [7:0] A_RX      = 8'h1C;
   localparam logic [7:0] A_CLKFREQ = 8'h20;
   localparam logic [7:0] A_THRESH  = 8'h24;
   localparam logic [7:0] A_ERRCNT  = 8'h28;

   logic             ie_tx, ie_rx, ie_err, ip_tx, ip_rx, ip_err;
   logic             rx_clr, tx_clr, tx_drop, ovr_q;
   logic [7:0]       tx_thr, rx_thr;
   logic [15:0]      perr_cnt, ovr_cnt;
   logic [7:0]       mem [TX_DEPTH];
   logic [TX_AW-1:0] wr_ptr, rd_ptr;
   logic [TX_AW:0]   tx_cnt;
   logic [7:0]       tx_items;
   logic             tx_full, tx_empty;
   logic             wr_ctrl, wr_stat, wr_tx, wr_thr, wr_err, rd_rx;
   logic             push, pop, drop, tx_flush, ovr_rise, perr_inc;
   logic             set_tx, set_rx, set_err;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   assign unused_wdata = ^wdata[31:25];

   assign wr_ctrl = wren && (addr == A_CONTROL);
   assign wr_stat = wren && (addr == A_STATUS);
   assign wr_tx   = wren && (addr == A_TX);
   assign wr_thr  = wren && (addr == A_THRESH);
   assign wr_err  = wren && (addr == A_ERRCNT);
   assign rd_rx   = rden && (addr == A_RX);

   assign tx_items = 8'(tx_cnt);
   assign tx_full  = (tx_cnt == TX_FULL_CNT);
   assign tx_empty = (tx_cnt == '0);
   assign tx_vld   = !tx_empty;
   assign txd      = tx_vld ? mem[rd_ptr] : '0;

   // Fullness is judged at the start of the cycle, so a same-cycle pop
   // does not make room for a push into a full FIFO.
   assign tx_flush = wr_ctrl && wdata[23];
   assign push     = wr_tx && !tx_full;
   assign drop     = wr_tx && tx_full;
   assign pop      = tx_done && tx_vld;
   assign ovr_rise = rx_overrun && !ovr_q;
   assign perr_inc = rd_rx && rx_vld && rx_perr;

   assign set_tx  = ie_tx && pop && !push && !tx_flush && ((tx_items - 8'd1) == tx_thr);
   assign set_rx  = ie_rx && rx_vld && (rx_items > rx_thr);
   assign set_err = ie_err && (ovr_rise || (rd_rx && rx_perr));

   assign irq      = (ie_tx && ip_tx) || (ie_rx && ip_rx) || (ie_err && ip_err);
   assign fifo_clr = rx_clr;

   always_comb begin
      rd_mux = '0;
      case (addr)
         A_VERSION: rd_mux = VERSION;
         A_NAME:    rd_mux = NAME;
         A_CONTROL: rd_mux = {7'h0, ie_err, tx_clr, rx_clr, ie_rx, ie_tx,
                             stop, even, parity, width, division};
         A_STATUS:  rd_mux = {16'h0, tx_items, tx_drop, rx_perr, tx_empty, tx_full,
                             rx_vld, ip_err, ip_rx, ip_tx};
         A_TX:      rd_mux = {tx_full, 23'h0, tx_items};
         A_RX:      rd_mux = {rx_vld, rx_perr, 6'h0, rx_items, 8'h0, rxd};
         A_CLKFREQ: rd_mux = CLK_FREQ;
         A_THRESH:  rd_mux = {16'h0, rx_thr, tx_thr};
         A_ERRCNT:  rd_mux = {ovr_cnt, perr_cnt};
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata[7:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata    <= '0;
         rx_done  <= 1'b0;
         division <= DIVISION;
         width    <= 1'b0;
         parity   <= 1'b0;
         even     <= 1'b0;
         stop     <= 1'b0;
         ie_tx    <= 1'b0;
         ie_rx    <= 1'b0;
         ie_err   <= 1'b0;
         ip_tx    <= 1'b0;
         ip_rx    <= 1'b0;
         ip_err   <= 1'b0;
         rx_clr   <= 1'b0;
         tx_clr   <= 1'b0;
         tx_drop  <= 1'b0;
         ovr_q    <= 1'b0;
         tx_thr   <= '0;
         rx_thr   <= '0;
         perr_cnt <= '0;
         ovr_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_cnt   <= '0;
      end else begin
         if (rden) rdata <= rd_mux;
         rx_done <= rd_rx && rx_vld;
         ovr_q   <= rx_overrun;

         rx_clr <= wr_ctrl && wdata[22];
         tx_clr <= tx_flush;
         if (wr_ctrl) begin
            division <= wdata[15:0];
            width    <= wdata[16];
            parity   <= wdata[17];
            even     <= wdata[18];
            stop     <= wdata[19];
            ie_tx    <= wdata[20];
            ie_rx    <= wdata[21];
            ie_err   <= wdata[24];
         end
         if (wr_thr) begin
            tx_thr <= wdata[7:0];
            rx_thr <= wdata[15:8];
         end

         // W1C clear wins over a same-cycle set.
         ip_tx   <= (ip_tx   || set_tx)  && !(wr_stat && wdata[0]);
         ip_rx   <= (ip_rx   || set_rx)  && !(wr_stat && wdata[1]);
         ip_err  <= (ip_err  || set_err) && !(wr_stat && wdata[2]);
         tx_drop <= (tx_drop || drop)    && !(wr_stat && wdata[7]);

         if (wr_err) begin
            perr_cnt <= '0;
            ovr_cnt  <= '0;
         end else begin
            if (perr_inc && (perr_cnt != '1)) perr_cnt <= perr_cnt + 16'd1;
            if (ovr_rise && (ovr_cnt != '1))  ovr_cnt  <= ovr_cnt + 16'd1;
         end

         if (tx_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            tx_cnt <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (pop && !push) tx_cnt <= tx_cnt - 1'b1;
         end
      end
   end

endmodule
